// File: rtl/led_channel_scheduler.sv
// led_channel_scheduler
// Multi-channel LED brightness controller. A shared PWM timebase and step
// prescaler drive per-channel mode state machines (off/steady/breathe/blink).
// A single-slot valid/ready config port reprograms one channel at a time;
// writes take effect only on PWM period boundaries so outputs never glitch.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   cfg_valid  configuration write request
//   cfg_ready  registered; high when the pending slot is free
//   cfg_chan   target channel (values >= CHANNELS are accepted and dropped)
//   cfg_mode   0 OFF, 1 STEADY, 2 BREATHE, 3 BLINK
//   cfg_level  steady level, or peak level for breathe/blink
//   led        registered LED drive, 1 = on
//
// Build option: define LED_GAMMA_EN to compare against (bright^2 >> PWM_BITS)
// instead of the linear brightness.
module led_channel_scheduler #(
    parameter int unsigned CHANNELS  = 8,
    parameter int unsigned PWM_BITS  = 7,
    parameter int unsigned STEP_BITS = 19
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [2:0]          cfg_chan,
    input  logic [1:0]          cfg_mode,
    input  logic [PWM_BITS-1:0] cfg_level,
    output logic [CHANNELS-1:0] led
);

    localparam int unsigned CHAN_BITS  = 3;
    localparam int unsigned BLINK_BITS = 5;
`ifdef LED_GAMMA_EN
    localparam int unsigned PROD_BITS  = 2 * PWM_BITS;
`endif

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_STEADY  = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_BLINK   = 2'd3
    } mode_t;

    typedef struct packed {
        logic [CHAN_BITS-1:0] chan;
        mode_t                mode;
        logic [PWM_BITS-1:0]  level;
    } cfg_t;

    logic [PWM_BITS-1:0]   duty_ctr;
    logic [STEP_BITS-1:0]  step_ctr;
    logic [BLINK_BITS-1:0] blink_ctr;
    cfg_t                  pend;

    mode_t               mode_q   [CHANNELS];
    mode_t               mode_d   [CHANNELS];
    logic [PWM_BITS-1:0] level_q  [CHANNELS];
    logic [PWM_BITS-1:0] level_d  [CHANNELS];
    logic [PWM_BITS-1:0] bright_q [CHANNELS];
    logic [PWM_BITS-1:0] bright_d [CHANNELS];
    logic                dir_q    [CHANNELS];
    logic                dir_d    [CHANNELS];
    logic [PWM_BITS-1:0] cmp_c    [CHANNELS];
`ifdef LED_GAMMA_EN
    logic [PROD_BITS-1:0] sq_c    [CHANNELS];
`endif

    logic pb_c;
    logic step_c;
    logic blink_phase_c;
    logic apply_c;

    // Shared strobes. The slot is pending exactly while cfg_ready is low, so a
    // write accepted on a boundary cycle cannot apply until the next boundary.
    always_comb begin
        pb_c          = &duty_ctr;
        step_c        = &step_ctr;
        blink_phase_c = blink_ctr[BLINK_BITS-1];
        apply_c       = !cfg_ready && pb_c;
    end

    // Per-channel mode FSM next state; an apply overrides a coincident step.
    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            mode_d[i]   = mode_q[i];
            level_d[i]  = level_q[i];
            bright_d[i] = bright_q[i];
            dir_d[i]    = dir_q[i];
            if (apply_c && (pend.chan == CHAN_BITS'(i))) begin
                mode_d[i]   = pend.mode;
                level_d[i]  = pend.level;
                bright_d[i] = '0;
                dir_d[i]    = 1'b1;
            end else if (step_c) begin
                case (mode_q[i])
                    MODE_OFF:    bright_d[i] = '0;
                    MODE_STEADY: bright_d[i] = level_q[i];
                    MODE_BREATHE: begin
                        // Each reversal spends one step holding, so nothing wraps.
                        if (dir_q[i]) begin
                            if (bright_q[i] >= level_q[i]) dir_d[i] = 1'b0;
                            else bright_d[i] = bright_q[i] + PWM_BITS'(1);
                        end else begin
                            if (bright_q[i] == '0) dir_d[i] = 1'b1;
                            else bright_d[i] = bright_q[i] - PWM_BITS'(1);
                        end
                    end
                    MODE_BLINK:  bright_d[i] = blink_phase_c ? level_q[i] : '0;
                    default:     bright_d[i] = '0;
                endcase
            end
        end
    end

    // Value compared against the PWM counter.
    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
`ifdef LED_GAMMA_EN
            sq_c[i]  = PROD_BITS'(bright_q[i]) * PROD_BITS'(bright_q[i]);
            cmp_c[i] = PWM_BITS'(sq_c[i] >> PWM_BITS);
`else
            cmp_c[i] = bright_q[i];
`endif
        end
    end

    // Counters, config slot, channel state and LED registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            duty_ctr   <= '0;
            step_ctr   <= '0;
            blink_ctr  <= '0;
            cfg_ready  <= 1'b1;
            pend.chan  <= '0;
            pend.mode  <= MODE_OFF;
            pend.level <= '0;
            led        <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                mode_q[i]   <= MODE_OFF;
                level_q[i]  <= '0;
                bright_q[i] <= '0;
                dir_q[i]    <= 1'b1;
            end
        end else begin
            duty_ctr <= duty_ctr + PWM_BITS'(1);
            step_ctr <= step_ctr + STEP_BITS'(1);
            if (step_c) blink_ctr <= blink_ctr + BLINK_BITS'(1);

            if (apply_c) begin
                cfg_ready <= 1'b1;
            end else if (cfg_valid && cfg_ready) begin
                cfg_ready  <= 1'b0;
                pend.chan  <= cfg_chan;
                pend.mode  <= mode_t'(cfg_mode);
                pend.level <= cfg_level;
            end

            for (int unsigned i = 0; i < CHANNELS; i++) begin
                mode_q[i]   <= mode_d[i];
                level_q[i]  <= level_d[i];
                bright_q[i] <= bright_d[i];
                dir_q[i]    <= dir_d[i];
                led[i]      <= (duty_ctr < cmp_c[i]);
            end
        end
    end

endmodule

// File: tb/tb_led_channel_scheduler.sv
// Testbench for led_channel_scheduler (CHANNELS=4, PWM_BITS=7, STEP_BITS=4).
// A time-indexed reference model predicts led and cfg_ready every cycle;
// table vectors and hand sequences cover handshake timing and corner cases.
module tb_led_channel_scheduler;

    localparam int CHANNELS  = 4;
    localparam int PWM_BITS  = 7;
    localparam int STEP_BITS = 4;
    localparam int PERIOD    = 1 << PWM_BITS;
    localparam int STEP_PER  = 1 << STEP_BITS;
    localparam int BOUND     = 4 * PERIOD;

    localparam logic [1:0] M_OFF     = 2'd0;
    localparam logic [1:0] M_STEADY  = 2'd1;
    localparam logic [1:0] M_BREATHE = 2'd2;
    localparam logic [1:0] M_BLINK   = 2'd3;

    logic                clk = 1'b0;
    logic                reset;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [2:0]          cfg_chan;
    logic [1:0]          cfg_mode;
    logic [PWM_BITS-1:0] cfg_level;
    logic [CHANNELS-1:0] led;

    int checks   = 0;
    int failures = 0;

    led_channel_scheduler #(
        .CHANNELS (CHANNELS),
        .PWM_BITS (PWM_BITS),
        .STEP_BITS(STEP_BITS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_chan (cfg_chan),
        .cfg_mode (cfg_mode),
        .cfg_level(cfg_level),
        .led      (led)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int                  m_t;          // clock edges since reset
    int                  m_blinks;     // steps since reset
    bit                  m_last_phase; // blink phase seen at the latest step
    bit                  m_ready;
    bit                  m_stepped;    // latest edge was a step
    int                  m_mode  [CHANNELS];
    int                  m_level [CHANNELS];
    int                  m_k     [CHANNELS]; // steps since last apply
    int                  p_chan, p_mode, p_level;
    logic [CHANNELS-1:0] exp_led;
    bit                  chk_en;

    function automatic int eff(input int b);
`ifdef LED_GAMMA_EN
        return (b * b) >> PWM_BITS;
`else
        return b;
`endif
    endfunction

    // Brightness as a function of steps since apply (triangle of period 2L+2).
    function automatic int bright_of(input int i);
        int l, p;
        l = m_level[i];
        if (m_k[i] == 0) return 0;
        case (m_mode[i])
            1: return l;
            2: begin
                p = m_k[i] % (2 * l + 2);
                return (p <= l) ? p : (2 * l + 1 - p);
            end
            3: return m_last_phase ? l : 0;
            default: return 0;
        endcase
    endfunction

    task automatic model_edge();
        int duty;
        bit stp, pb, apply;
        if (reset) begin
            m_t = 0; m_blinks = 0; m_last_phase = 0; m_ready = 1; m_stepped = 0;
            exp_led = '0;
            for (int i = 0; i < CHANNELS; i++) begin
                m_mode[i] = 0; m_level[i] = 0; m_k[i] = 0;
            end
        end else begin
            duty  = m_t % PERIOD;
            stp   = (m_t % STEP_PER) == STEP_PER - 1;
            pb    = duty == PERIOD - 1;
            apply = !m_ready && pb;
            for (int i = 0; i < CHANNELS; i++) exp_led[i] = duty < eff(bright_of(i));
            for (int i = 0; i < CHANNELS; i++) begin
                if (apply && p_chan == i) begin
                    m_mode[i] = p_mode; m_level[i] = p_level; m_k[i] = 0;
                end else if (stp) begin
                    m_k[i]++;
                end
            end
            if (stp) begin
                m_last_phase = (m_blinks % 32) >= 16;
                m_blinks++;
            end
            if (apply) m_ready = 1;
            else if (cfg_valid && m_ready) begin
                m_ready = 0; p_chan = int'(cfg_chan); p_mode = int'(cfg_mode); p_level = int'(cfg_level);
            end
            m_stepped = stp;
            m_t++;
        end
    endtask

    initial begin : model
        forever begin
            @(posedge clk);
            model_edge();
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("led_vs_model", 32'(led), 32'(exp_led));
                check("ready_vs_model", 32'(cfg_ready), 32'(m_ready));
            end
        end
    end

    initial begin : watchdog
        #4000000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    // Drive one write and return after the accepting edge with its duty value.
    task automatic cfg_write(input logic [2:0] ch, input logic [1:0] md,
                             input logic [PWM_BITS-1:0] lv, output int d_acc);
        int n;
        n = 0;
        @(negedge clk);
        cfg_valid = 1'b1; cfg_chan = ch; cfg_mode = md; cfg_level = lv;
        while (cfg_ready !== 1'b1 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 32'(cfg_ready), 32'd1);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        d_acc = (m_t - 1) % PERIOD;
    endtask

    // Edges from acceptance until cfg_ready is seen high again.
    task automatic wait_apply(output int lat, output logic first);
        int n;
        n = 0;
        @(negedge clk);
        first = cfg_ready;
        while (cfg_ready !== 1'b1 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        lat = n;
    endtask

    function automatic int exp_lat(input int d);
        return (d == PERIOD - 1) ? PERIOD : PERIOD - 1 - d;
    endfunction

    int cnt_ch [CHANNELS];
    task automatic count_all();
        for (int c = 0; c < CHANNELS; c++) cnt_ch[c] = 0;
        repeat (PERIOD) begin
            @(negedge clk);
            for (int c = 0; c < CHANNELS; c++) if (led[c]) cnt_ch[c]++;
        end
    endtask

    typedef struct {
        logic [2:0]          chan;
        logic [1:0]          mode;
        logic [PWM_BITS-1:0] level;
        int                  exp_on;
    } vec_t;

    // ---------------- main sequence ----------------
    initial begin : main
        vec_t vec [7];
        int   cur [CHANNELS];
        int   seq [13];
        int   d, d2, lat, n, bad;
        logic first;

        vec[0] = '{3'd2, M_STEADY, 7'd32,  eff(32)};
        vec[1] = '{3'd1, M_STEADY, 7'd127, eff(127)};
        vec[2] = '{3'd3, M_STEADY, 7'd0,   0};
        vec[3] = '{3'd0, M_STEADY, 7'd64,  eff(64)};
        vec[4] = '{3'd2, M_OFF,    7'd50,  0};
        vec[5] = '{3'd3, M_STEADY, 7'd11,  eff(11)};
        vec[6] = '{3'd7, M_STEADY, 7'd100, 0};
        seq = '{1, 2, 3, 4, 5, 5, 4, 3, 2, 1, 0, 0, 1};
        for (int c = 0; c < CHANNELS; c++) cur[c] = 0;

        reset = 1'b1; cfg_valid = 1'b0; cfg_chan = '0; cfg_mode = '0; cfg_level = '0; chk_en = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_en = 1;
        check("reset_led", 32'(led), 32'd0);
        check("reset_ready", 32'(cfg_ready), 32'd1);

        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (led !== '0 || cfg_ready !== 1'b1) bad++;
        end
        check("idle_dark_ready", 32'(bad), 32'd0);

        // Table vectors: handshake latency and per-period on-counts.
        for (int v = 0; v < 7; v++) begin
            cfg_write(vec[v].chan, vec[v].mode, vec[v].level, d);
            wait_apply(lat, first);
            check($sformatf("vec%0d_ready_low", v), 32'(first), 32'd0);
            check($sformatf("vec%0d_apply_latency", v), 32'(lat), 32'(exp_lat(d)));
            if (int'(vec[v].chan) < CHANNELS) cur[vec[v].chan] = vec[v].exp_on;
            repeat (STEP_PER + 4) @(negedge clk);
            count_all();
            for (int c = 0; c < CHANNELS; c++)
                check($sformatf("vec%0d_ch%0d_on", v, c), 32'(cnt_ch[c]), 32'(cur[c]));
        end

        // Acceptance on a boundary cycle waits a full period.
        n = 0;
        while ((m_t % PERIOD) != PERIOD - 2 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        cfg_write(3'd2, M_STEADY, 7'd16, d);
        check("pb_accept_duty", 32'(d), 32'(PERIOD - 1));
        wait_apply(lat, first);
        check("pb_accept_latency", 32'(lat), 32'(PERIOD));
        cur[2] = eff(16);
        repeat (STEP_PER + 4) @(negedge clk);
        count_all();
        check("pb_accept_ch2_on", 32'(cnt_ch[2]), 32'(cur[2]));

        // Breathe on channel 0, level 5: apply coincides with a step.
        cfg_write(3'd0, M_BREATHE, 7'd5, d);
        wait_apply(lat, first);
        for (int s = 0; s < 13; s++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!m_stepped && n < BOUND);
            check($sformatf("breathe_step%0d", s), 32'(dut.bright_q[0]), 32'(seq[s]));
        end

        // Back-to-back writes: the second stalls until the first applies.
        cfg_write(3'd1, M_STEADY, 7'd20, d);
        cfg_write(3'd3, M_STEADY, 7'd40, d2);
        check("b2b_second_accept_duty", 32'(d2), 32'd0);
        wait_apply(lat, first);
        check("b2b_second_latency", 32'(lat), 32'(exp_lat(d2)));
        repeat (STEP_PER + 4) @(negedge clk);
        count_all();
        check("b2b_ch1_on", 32'(cnt_ch[1]), 32'(eff(20)));
        check("b2b_ch3_on", 32'(cnt_ch[3]), 32'(eff(40)));

        // Reset with a write pending drops it and clears everything.
        cfg_write(3'd2, M_STEADY, 7'd90, d);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("reset_mid_ready", 32'(cfg_ready), 32'd1);
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (led !== '0) bad++;
        end
        check("reset_mid_dark", 32'(bad), 32'd0);

        // Randomized writes; the per-cycle model comparison does the checking.
        for (int r = 0; r < 30; r++) begin
            cfg_write(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                      7'($urandom_range(0, 127)), d);
            repeat ($urandom_range(0, 200)) @(negedge clk);
        end
        repeat (1200) @(negedge clk);

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
